seq_bit_serializer: RTL
=======================

Name: seq_bit_serializer

Overview:
Upstream feeder for sequence_detector. Accepts parallel words over a valid/ready handshake and shifts each word out one bit per clock on x. The x output connects directly to the detector's x input. Supports back-to-back streaming or an optional fixed idle gap between words, and counts completed words for debug and scoreboarding.

Parameters:
WIDTH, 8, bits per word (>=1)
GAP, 0, idle cycles (x=0, x_valid=0) inserted between consecutive words; 0 = continuous stream
MSB_FIRST, 1, 1: bit WIDTH-1 sent first; 0: bit 0 sent first

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-low reset (0 = reset, sampled on rising clk)
din  input  WIDTH  parallel word to serialize
din_valid  input  1  din holds a word to send
din_ready  output  1  block can accept a word this cycle
x  output  1  serial bit to sequence_detector.x
x_valid  output  1  x carries a data bit this cycle
last_bit  output  1  current x is the final bit of the word
busy  output  1  state != IDLE
words_sent  output  16  count of fully shifted words, wraps

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (rst=0 at a clk edge):
  - state=IDLE; shift reg, bit counter and gap counter = 0; words_sent=0.
  - x=0, x_valid=0, last_bit=0, busy=0.
  - din_ready is combinationally forced to 0 while rst=0.
- States: IDLE, SHIFT, GAP.
- Handshake: a word is accepted on a rising edge where din_valid=1 and din_ready=1. din is ignored at all other times. din_ready is decoded from state and counters only, never from din_valid.
- IDLE:
  - din_ready=1; x=0; x_valid=0.
  - On accept: load shift reg with din (bit-reversed if MSB_FIRST=0), set bit counter=WIDTH-1, go to SHIFT.
  - Latency: first bit appears on x the cycle after the accepting edge.
- SHIFT:
  - x = shift reg MSB; x_valid=1; last_bit=1 when bit counter=0.
  - Each edge: shift left by 1, decrement bit counter.
  - At the edge leaving the last bit: words_sent += 1 (16'hFFFF wraps to 0).
  - Next state if GAP=0: din_ready=1 during the last-bit cycle. On accept, go directly into the new word's first bit (no bubble); otherwise go to IDLE.
  - Next state if GAP>0: din_ready=0 during SHIFT; go to GAP with gap counter=GAP-1.
- GAP:
  - x=0; x_valid=0; gap counter decrements each cycle.
  - din_ready=1 only when gap counter=0. An accept there goes straight to SHIFT, so exactly GAP bubble cycles separate words; with no accept, go to IDLE.
- Register rules: x, x_valid, last_bit and busy derive only from registered state, with no combinational path from din or din_valid. x=0 whenever x_valid=0.
- WIDTH=1: every SHIFT cycle is a last-bit cycle; the same rules apply.
- Reset mid-word or mid-gap: the word is aborted and not counted. Reset values take effect the cycle after the reset edge, and no partial bits follow the release.
- din_valid=1 while rst=0 is ignored; the word must be re-presented after release.

Test Plan:
- Reset: rst=0 for 3 cycles with din_valid=1 -> x=0, x_valid=0, din_ready=0, words_sent=0 throughout. After rst=1, din_ready=1 in IDLE.
- Single word, WIDTH=8, GAP=0, din=8'hB2 -> starting the cycle after accept, x=1,0,1,1,0,0,1,0 with x_valid=1 for 8 cycles. last_bit=1 on the 8th cycle only; then words_sent=1, state IDLE, x=0.
- Back-to-back, GAP=0: din_valid held with 8'hFF then 8'h00 -> 16 contiguous x_valid cycles (eight 1s then eight 0s), no bubble; din_ready=1 only on the accept cycles; words_sent=2.
- GAP=2, MSB_FIRST=0: words 8'h01 and 8'h80 -> x=1,0,0,0,0,0,0,0, then exactly 2 cycles x_valid=0, then 0,0,0,0,0,0,0,1; words_sent=2.
- Reset mid-word: send 8'hF0; drop rst=0 after the 3rd bit -> x=0 and x_valid=0 the cycle after the reset edge; words_sent stays 0; after release a new word 8'h0F serializes correctly.
- Wrap: WIDTH=2, GAP=0, stream 65537 words -> words_sent reads 16'h0001.

Source files
------------

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for sequence_detector: accepts words over valid/ready
// and shifts them out one bit per clock on x, with an optional fixed idle gap.
module seq_bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned GAP       = 0,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             last_bit,
    output logic             busy,
    output logic [15:0]      words_sent
);

    localparam int unsigned CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int unsigned BIT_LAST = WIDTH - 1;
    localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             state_q, state_n;
    logic [WIDTH-1:0]   shreg_q, shreg_n;
    logic [CNT_W-1:0]   bitcnt_q, bitcnt_n;
    logic [GAP_W-1:0]   gapcnt_q, gapcnt_n;
    logic [15:0]        words_q, words_n;
    logic               x_n, x_valid_n, last_bit_n, busy_n;
    logic               accept;

    // The shifter always emits its MSB, so LSB-first words are loaded reversed.
    function automatic logic [WIDTH-1:0] order_word(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        r = w;
        if (!MSB_FIRST) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                r[i] = w[WIDTH-1-i];
            end
        end
        return r;
    endfunction

    // Ready decodes from state and counters only; held low while in reset.
    always_comb begin
        din_ready = 1'b0;
        case (state_q)
            S_IDLE:  din_ready = 1'b1;
            S_SHIFT: din_ready = (GAP == 0) && (bitcnt_q == '0);
            S_GAP:   din_ready = (gapcnt_q == '0);
            default: din_ready = 1'b0;
        endcase
        if (!rst) begin
            din_ready = 1'b0;
        end
        accept = din_valid && din_ready;
    end

    always_comb begin
        state_n  = state_q;
        shreg_n  = shreg_q;
        bitcnt_n = bitcnt_q;
        gapcnt_n = gapcnt_q;
        words_n  = words_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    shreg_n  = order_word(din);
                    bitcnt_n = CNT_W'(BIT_LAST);
                    state_n  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shreg_n  = shreg_q << 1;
                bitcnt_n = bitcnt_q - CNT_W'(1);
                if (bitcnt_q == '0) begin
                    words_n  = words_q + 16'd1;
                    bitcnt_n = '0;
                    if (GAP == 0) begin
                        // Streaming mode: a waiting word starts with no bubble.
                        if (accept) begin
                            shreg_n  = order_word(din);
                            bitcnt_n = CNT_W'(BIT_LAST);
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        state_n  = S_GAP;
                        gapcnt_n = GAP_W'(GAP_LAST);
                    end
                end
            end
            S_GAP: begin
                if (gapcnt_q == '0) begin
                    if (accept) begin
                        shreg_n  = order_word(din);
                        bitcnt_n = CNT_W'(BIT_LAST);
                        state_n  = S_SHIFT;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    gapcnt_n = gapcnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        x_valid_n  = (state_n == S_SHIFT);
        x_n        = x_valid_n ? shreg_n[WIDTH-1] : 1'b0;
        last_bit_n = x_valid_n && (bitcnt_n == '0);
        busy_n     = (state_n != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            gapcnt_q <= '0;
            words_q  <= '0;
            x        <= 1'b0;
            x_valid  <= 1'b0;
            last_bit <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_n;
            shreg_q  <= shreg_n;
            bitcnt_q <= bitcnt_n;
            gapcnt_q <= gapcnt_n;
            words_q  <= words_n;
            x        <= x_n;
            x_valid  <= x_valid_n;
            last_bit <= last_bit_n;
            busy     <= busy_n;
        end
    end

    assign words_sent = words_q;

endmodule
